// File: rtl/am_lock_rx.sv
// -----------------------------------------------------------------------------
// am_lock_rx
// Receive-side alignment marker lock for one 40GBASE-R PCS lane. It searches
// the (unscrambled) 66b block stream for any of the four lane markers. It
// acquires lock once a second marker with the same lane id arrives exactly one
// marker period later. While locked it flags every marker slot so that
// downstream deskew logic can read the lane id and strip the marker.
//
// Ports
//   clk, reset     : clock, asynchronous active-high reset
//   block_lock_i   : block sync lock for this lane (0 forces loss of lock)
//   valid_i        : head_i/data_i carry a block this cycle
//   head_i, data_i : sync header and block payload
//   valid_o        : registered valid_i
//   head_o, data_o : registered block (held while valid_i is 0)
//   marker_v_o     : output block is an alignment marker slot
//   lock_o         : marker lock acquired
//   lane_o         : captured lane id (meaningful while lock_o is 1)
// -----------------------------------------------------------------------------
module am_lock_rx #(
   parameter int                DATA_W    = 64,
   parameter int                HEAD_W    = 2,
   parameter int                LANE_N    = 4,
   parameter int                LANE_W    = $clog2(LANE_N),
   parameter int                AM_GAP    = 16384,
   parameter int                INV_MAX   = 4,
   parameter logic [HEAD_W-1:0] CTRL_HEAD = 2'b10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              block_lock_i,
   input  logic              valid_i,
   input  logic [HEAD_W-1:0] head_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [HEAD_W-1:0] head_o,
   output logic [DATA_W-1:0] data_o,
   output logic              marker_v_o,
   output logic              lock_o,
   output logic [LANE_W-1:0] lane_o
);

   localparam int CNT_W = $clog2(AM_GAP);
   localparam int INV_W = $clog2(INV_MAX + 1);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_FIRST    = 2'd1,
      ST_LOCKED   = 2'd2
   } state_t;

   // Marker bytes packed as {M2, M1, M0}: byte 0 sits in the LSBs of the payload.
   function automatic logic [23:0] am_value(input int lane);
      logic [23:0] v;
      case (lane)
         32'sd0:  v = 24'h477690;
         32'sd1:  v = 24'hE6C4F0;
         32'sd2:  v = 24'h9B65C5;
         32'sd3:  v = 24'h3D79A2;
         default: v = 24'h000000;
      endcase
      return v;
   endfunction

   // Bytes 0..2 carry the marker, bytes 4..6 its complement; BIP bytes 3 and 7 are ignored.
   function automatic logic is_marker(input logic [HEAD_W-1:0] head,
                                      input logic [DATA_W-1:0] data,
                                      input int                lane);
      logic [23:0] m;
      m = am_value(lane);
      return (head == CTRL_HEAD) && (data[23:0] == m) && (data[55:32] == ~m);
   endfunction

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [INV_W-1:0]  r_inv;
   logic [LANE_W-1:0] r_lane;
   logic              r_valid;
   logic [HEAD_W-1:0] r_head;
   logic [DATA_W-1:0] r_data;
   logic              r_marker_v;
   logic              r_lock;

   logic [LANE_N-1:0] w_match_vec;
   logic              w_any_match;
   logic [LANE_W-1:0] w_match_id;
   logic              w_id_match;
   logic              w_slot;

   for (genvar k = 0; k < LANE_N; k++) begin : g_match
      assign w_match_vec[k] = is_marker(head_i, data_i, k);
   end

   // Lane id of the matching marker; marker encodings are mutually exclusive,
   // so OR-ing the one-hot hits yields the id directly.
   always_comb begin
      w_match_id  = {LANE_W{1'b0}};
      w_any_match = |w_match_vec;
      for (int k = 0; k < LANE_N; k++) begin
         w_match_id = w_match_id | (LANE_W'(k) & {LANE_W{w_match_vec[k]}});
      end
   end

   assign w_id_match = w_match_vec[r_lane];
   assign w_slot     = valid_i && (r_cnt == CNT_W'(AM_GAP - 1));

   // Lock state machine, block counter and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_UNLOCKED;
         r_cnt      <= {CNT_W{1'b0}};
         r_inv      <= {INV_W{1'b0}};
         r_lane     <= {LANE_W{1'b0}};
         r_valid    <= 1'b0;
         r_head     <= {HEAD_W{1'b0}};
         r_data     <= {DATA_W{1'b0}};
         r_marker_v <= 1'b0;
         r_lock     <= 1'b0;
      end else begin
         r_valid    <= valid_i;
         r_marker_v <= 1'b0;
         if (valid_i) begin
            r_head <= head_i;
            r_data <= data_i;
         end
         if (!block_lock_i) begin
            r_state <= ST_UNLOCKED;
            r_cnt   <= {CNT_W{1'b0}};
            r_inv   <= {INV_W{1'b0}};
            r_lock  <= 1'b0;
         end else if (valid_i) begin
            case (r_state)
               ST_UNLOCKED: begin
                  if (w_any_match) begin
                     r_lane  <= w_match_id;
                     r_cnt   <= {CNT_W{1'b0}};
                     r_state <= ST_FIRST;
                  end
               end
               ST_FIRST: begin
                  if (w_slot) begin
                     r_cnt <= {CNT_W{1'b0}};
                     if (w_id_match) begin
                        r_state    <= ST_LOCKED;
                        r_inv      <= {INV_W{1'b0}};
                        r_lock     <= 1'b1;
                        r_marker_v <= 1'b1;
                     end else begin
                        // the failing block is deliberately not retried as a first marker
                        r_state <= ST_UNLOCKED;
                     end
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               ST_LOCKED: begin
                  if (w_slot) begin
                     r_cnt      <= {CNT_W{1'b0}};
                     r_marker_v <= 1'b1;
                     if (w_id_match) begin
                        r_inv <= {INV_W{1'b0}};
                     end else if (r_inv == INV_W'(INV_MAX - 1)) begin
                        r_state <= ST_UNLOCKED;
                        r_inv   <= {INV_W{1'b0}};
                        r_lock  <= 1'b0;
                     end else begin
                        r_inv <= r_inv + INV_W'(1);
                     end
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               default: begin
                  r_state <= ST_UNLOCKED;
                  r_cnt   <= {CNT_W{1'b0}};
                  r_inv   <= {INV_W{1'b0}};
                  r_lock  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign valid_o    = r_valid;
   assign head_o     = r_head;
   assign data_o     = r_data;
   assign marker_v_o = r_marker_v;
   assign lock_o     = r_lock;
   assign lane_o     = r_lane;

endmodule

// File: doc/am_lock_rx.md
# am_lock_rx

Receive-side alignment marker lock for one 40GBASE-R PCS lane; the receive counterpart of the transmit alignment marker inserter. It sits after per-lane block sync and descrambler bypass (markers are unscrambled), searches the 66b block stream for any of the four 40G lane markers, and acquires lock after two markers one period apart. Once locked, it flags every marker slot so downstream deskew/reorder logic can use the lane id and strip the marker. One instance is used per physical lane.

## Interface
- `DATA_W`, default 64: block payload width.
- `HEAD_W`, default 2: sync header width.
- `LANE_N`, default 4: number of PCS lanes, and so of marker encodings.
- `LANE_W`, default `$clog2(LANE_N)`: lane id width.
- `AM_GAP`, default 16384: marker period in valid blocks, marker included. Must be ≥ 2.
- `INV_MAX`, default 4: number of consecutive bad marker slots that drops lock.
- `CTRL_HEAD`, default 2'b10: control-block sync header value.
- `clk`, input, 1: clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `block_lock_i`, input, 1: block sync lock for this lane.
- `valid_i`, input, 1: `head_i`/`data_i` carry a block this cycle.
- `head_i`, input, `HEAD_W`: sync header.
- `data_i`, input, `DATA_W`: block payload.
- `valid_o`, output, 1: registered copy of `valid_i`.
- `head_o`, output, `HEAD_W`: registered copy of `head_i`.
- `data_o`, output, `DATA_W`: registered copy of `data_i`.
- `marker_v_o`, output, 1: the current output block is an alignment marker slot.
- `lock_o`, output, 1: marker lock acquired.
- `lane_o`, output, `LANE_W`: locked lane id; valid only while `lock_o` is 1.

## Operation
- **Marker match.** A block matches lane k when all of these hold:
  - `head_i == CTRL_HEAD`;
  - bytes 0..2 (`data_i[23:0]`, byte 0 in the LSBs) equal M0,M1,M2 of lane k;
  - bytes 4..6 equal ~M0,~M1,~M2;
  - bytes 3 and 7 (BIP) are ignored.
- **Marker values** (M0,M1,M2):
  - lane 0: 0x90,0x76,0x47
  - lane 1: 0xF0,0xC4,0xE6
  - lane 2: 0xC5,0x65,0x9B
  - lane 3: 0xA2,0x79,0x3D
- **Block counter.** `cnt` is `$clog2(AM_GAP)` bits wide and advances only on `valid_i`. A slot is expected when `cnt == AM_GAP-1` and `valid_i`. At each expected slot, `cnt` wraps to 0.
- **State machine.**
  - UNLOCKED:
    - On a valid matching block: capture the lane id, clear `cnt`, go to FIRST.
    - Otherwise stay.
  - FIRST (counting toward the expected slot):
    - Slot block matches the captured id: go to LOCKED and clear `inv_cnt`.
    - Slot block does not match: go to UNLOCKED. That block is not re-evaluated as a new first marker.
  - LOCKED, at each slot:
    - Match with the captured id: clear `inv_cnt`.
    - Otherwise (including a match with a different lane id): increment `inv_cnt`.
    - When `inv_cnt` reaches `INV_MAX`: go to UNLOCKED.
- **Loss of block lock.** `block_lock_i == 0` forces UNLOCKED from any state and clears `cnt` and `inv_cnt`; it has priority over all matching. While it is 0, no search takes place.
- **`marker_v_o`** is 1 for:
  - the confirming block on the FIRST→LOCKED transition;
  - every expected slot block while in LOCKED, including bad slots that do not yet drop lock, and including the slot that drops lock.
- **`lane_o`** holds the captured id from FIRST onward. It is meaningful only while `lock_o` is 1.

## Timing
- Latency is one cycle on every output path: `valid_i`/`head_i`/`data_i` → `valid_o`/`head_o`/`data_o`. `marker_v_o` and `lock_o` are aligned with the `data_o` block they describe.
- `lock_o` rises in the same output cycle as the confirming marker's `marker_v_o`.
- `lock_o` falls in the output cycle of the `INV_MAX`-th consecutive bad slot; `marker_v_o` is also 1 in that cycle.
- `lock_o` falls one cycle after `block_lock_i` is sampled low.
- Cycles with `valid_i == 0`:
  - state and `cnt` hold;
  - `valid_o` and `marker_v_o` are 0;
  - `data_o`/`head_o` hold their last values;
  - `lock_o` holds.
- Reset (asynchronous, at any time including mid-lock) drives all outputs to 0, state to UNLOCKED, and `cnt`, `inv_cnt` and the lane id to 0. Operation resumes on the first clock edge after `reset` deasserts.
- There is no backpressure; a block is accepted every cycle that `valid_i` is high.

## Test plan
- **Acquire lock.** `AM_GAP=8`, `block_lock_i=1`, lane-2 marker at valid blocks 0, 8, 16, filler elsewhere → `lock_o=1`, `marker_v_o=1` and `lane_o=2` in the output cycle of block 8; `marker_v_o=1` again at block 16.
- **Wrong second marker.** Lane-1 marker at block 0, lane-3 marker at blocks 8 and 16, lane-3 marker at block 24 → no lock at block 8; lock with `lane_o=3` at block 24.
- **Lock loss after `INV_MAX` bad slots.** Locked on lane 0; corrupt M1 at 3 consecutive slots, then a good slot → `lock_o` stays 1 and `marker_v_o` pulses at all 4 slots. Then corrupt 4 consecutive slots → `lock_o` drops with the 4th slot's output.
- **Valid gaps.** Insert random `valid_i=0` cycles between blocks → lock is still acquired at valid block 8; `valid_o` is 0 in gap cycles; `marker_v_o` is never 1 in a gap.
- **Header filter.** A correct lane-0 payload with `head_i=2'b01` at blocks 0 and 8 → `lock_o` stays 0.
- **Block lock drop and reset.** `block_lock_i` dropped for one cycle while locked → `lock_o=0` on the next cycle and re-acquisition takes two more markers. `reset` pulsed asynchronously mid-block → all outputs read 0 before the next clock edge.
